uart_core: RTL and testbench

//  8N1 UART core: a baud/oversample tick generator, a transmitter and a receiver in one clock domain.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 46 ++++
 rtl/uart_core.sv | 219 +++++++++++++++++++++
 tb/tb_uart_core.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the 8N1 UART core.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Clock cycles per tick for a given line rate and oversample factor (integer division).
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running tick generators: one pulse per tx bit period, one per rx oversample period.
module uart_baud_gen #(
    parameter int unsigned TX_DIV = 5208,
    parameter int unsigned RX_DIV = 325
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick1,
    output logic baud_tick2
);

    localparam int unsigned TX_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int unsigned RX_W = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

    logic [TX_W-1:0] tx_cnt;
    logic [RX_W-1:0] rx_cnt;

    // Tx bit-rate counter: pulse when the count reaches TX_DIV-1, then wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt     <= '0;
            baud_tick1 <= 1'b0;
        end else if (tx_cnt == TX_W'(TX_DIV - 1)) begin
            tx_cnt     <= '0;
            baud_tick1 <= 1'b1;
        end else begin
            tx_cnt     <= tx_cnt + TX_W'(1);
            baud_tick1 <= 1'b0;
        end
    end

    // Rx oversample counter: pulse when the count reaches RX_DIV-1, then wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt     <= '0;
            baud_tick2 <= 1'b0;
        end else if (rx_cnt == RX_W'(RX_DIV - 1)) begin
            rx_cnt     <= '0;
            baud_tick2 <= 1'b1;
        end else begin
            rx_cnt     <= rx_cnt + RX_W'(1);
            baud_tick2 <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART: tick generator, transmitter and receiver sharing one clock domain.
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       baud_tick1,
    output logic       baud_tick2
);

    localparam int unsigned TX_DIV    = baud_div(CLK_FREQ, BAUD, 1);
    localparam int unsigned RX_DIV    = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned BIT_W     = $clog2(DATA_BITS);
    localparam int unsigned OS_W      = $clog2(OVERSAMPLE);
    localparam int unsigned MID_TICK  = OVERSAMPLE / 2 - 1;
    localparam int unsigned LAST_TICK = OVERSAMPLE - 1;

    uart_baud_gen #(
        .TX_DIV (TX_DIV),
        .RX_DIV (RX_DIV)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .baud_tick1 (baud_tick1),
        .baud_tick2 (baud_tick2)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e              tx_state, tx_state_n;
    logic [DATA_BITS-1:0]   tx_shreg, tx_shreg_n;
    logic [BIT_W-1:0]       tx_bit, tx_bit_n;
    logic                   busy_n;
    logic                   tx_n;

    // Tx state and line registers; tx line is registered alongside the state it reflects.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_shreg <= '0;
            tx_bit   <= '0;
            busy     <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_shreg <= tx_shreg_n;
            tx_bit   <= tx_bit_n;
            busy     <= busy_n;
            tx       <= tx_n;
        end
    end

    // Tx next-state: a byte accepted in IDLE waits (busy) for the next bit tick to start.
    always_comb begin
        tx_state_n = tx_state;
        tx_shreg_n = tx_shreg;
        tx_bit_n   = tx_bit;
        busy_n     = busy;
        tx_n       = 1'b1;

        case (tx_state)
            TX_IDLE: begin
                if (!busy && wr_en) begin
                    tx_shreg_n = data_in;
                    busy_n     = 1'b1;
                end else if (busy && baud_tick1) begin
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (baud_tick1) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = '0;
                end
            end
            TX_DATA: begin
                if (baud_tick1) begin
                    if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n = tx_bit + BIT_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (baud_tick1) begin
                    tx_state_n = TX_IDLE;
                    busy_n     = 1'b0;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        case (tx_state_n)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = tx_shreg_n[tx_bit_n];
            default:  tx_n = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]             rx_sync;
    logic                   rx_s;
    rx_state_e              rx_state, rx_state_n;
    logic [OS_W-1:0]        os_cnt, os_cnt_n;
    logic [BIT_W-1:0]       rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0]   rx_shreg, rx_shreg_n;
    logic [DATA_BITS-1:0]   data_out_n;
    logic                   rdy_n;
    logic                   rdy_set;

    // Two-flop synchronizer for the asynchronous rx pin; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s = rx_sync[1];

    // Rx state, sample counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            os_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            data_out <= '0;
            rdy      <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            os_cnt   <= os_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shreg <= rx_shreg_n;
            data_out <= data_out_n;
            rdy      <= rdy_n;
        end
    end

    // Rx next-state: mid-bit sampling on the oversample tick; only a good stop bit publishes.
    always_comb begin
        rx_state_n = rx_state;
        os_cnt_n   = os_cnt;
        rx_bit_n   = rx_bit;
        rx_shreg_n = rx_shreg;
        data_out_n = data_out;
        rdy_set    = 1'b0;

        if (baud_tick2) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state_n = RX_START;
                        os_cnt_n   = '0;
                    end
                end
                RX_START: begin
                    if (os_cnt == OS_W'(MID_TICK)) begin
                        os_cnt_n = '0;
                        if (rx_s) begin
                            rx_state_n = RX_IDLE;
                        end else begin
                            rx_state_n = RX_DATA;
                            rx_bit_n   = '0;
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
                RX_DATA: begin
                    if (os_cnt == OS_W'(LAST_TICK)) begin
                        os_cnt_n   = '0;
                        rx_shreg_n = {rx_s, rx_shreg[DATA_BITS-1:1]};
                        if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
                            rx_state_n = RX_STOP;
                        end else begin
                            rx_bit_n = rx_bit + BIT_W'(1);
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
                RX_STOP: begin
                    if (os_cnt == OS_W'(LAST_TICK)) begin
                        os_cnt_n   = '0;
                        rx_state_n = RX_IDLE;
                        if (rx_s) begin
                            data_out_n = rx_shreg;
                            rdy_set    = 1'b1;
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end

        // A completing byte takes priority over a same-cycle clear.
        rdy_n = rdy_set | (rdy & ~rdy_clr);
    end

endmodule

// File: tb/tb_uart_core.sv
// Randomized scoreboard bench for uart_core (loopback, injected rx frames, timing, reset).
module tb_uart_core;

    localparam int unsigned CLK_FREQ = 614_400;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned TX_DIV   = CLK_FREQ / BAUD;          // 64 clk per bit
    localparam int unsigned RX_DIV   = CLK_FREQ / (16 * BAUD);   // 4 clk per oversample

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data_out;
    logic       rdy;
    logic       baud_tick1;
    logic       baud_tick2;

    logic       loopback;
    logic       rx_drv;

    assign rx = loopback ? tx : rx_drv;

    uart_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .tx         (tx),
        .busy       (busy),
        .rx         (rx),
        .rdy_clr    (rdy_clr),
        .data_out   (data_out),
        .rdy        (rdy),
        .baud_tick1 (baud_tick1),
        .baud_tick2 (baud_tick2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    bit         auto_clr  = 1'b1;
    bit         clr_req   = 1'b0;
    logic       tx_arr [10*TX_DIV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each new rdy pops the oldest expected byte; optionally acknowledges it.
    initial begin : monitor
        logic rdy_prev;
        logic [7:0] e;
        logic rising;
        rdy_prev = 1'b0;
        rdy_clr  = 1'b0;
        forever begin
            @(negedge clk);
            rising = 1'b0;
            if (rst) begin
                rdy_prev = 1'b0;
            end else begin
                rising = rdy && !rdy_prev;
                if (rising) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_unexpected: data_out=0x%0h while no byte was expected (t=%0t)",
                                 data_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(data_out), 32'(e));
                        last_good = e;
                    end
                end
                rdy_prev = rdy;
            end
            rdy_clr = clr_req | (auto_clr & rising);
        end
    end

    // Hard stop if the run ever stalls.
    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 12 * TX_DIV) begin
            @(negedge clk);
            c++;
        end
        check("busy_release", 32'(busy), 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        wait_idle();
        @(negedge clk);
        wr_en   = 1'b1;
        data_in = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Drive one 8N1 frame onto rx at the nominal bit rate, then idle for three bits.
    task automatic inject(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (TX_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (TX_DIV) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (TX_DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * TX_DIV) @(negedge clk);
    endtask

    initial begin : stim
        int         c;
        int         busy_cnt;
        int         zeros;
        int         busy_seen;
        logic [9:0] frame;
        logic       ok;
        logic [7:0] b;
        logic [7:0] b2;
        logic       stop_ok;
        logic [7:0] fixed [5];

        fixed[0] = 8'hA5; fixed[1] = 8'h5A; fixed[2] = 8'hCB; fixed[3] = 8'hFF; fixed[4] = 8'h00;

        rst      = 1'b1;
        wr_en    = 1'b0;
        data_in  = 8'h00;
        rx_drv   = 1'b1;
        loopback = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx",       32'(tx),         32'd1);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_rdy",      32'(rdy),        32'd0);
        check("rst_data_out", 32'(data_out),   32'd0);
        check("rst_tick1",    32'(baud_tick1), 32'd0);
        check("rst_tick2",    32'(baud_tick2), 32'd0);
        rst = 1'b0;

        // Tick period and pulse width
        c = 0;
        while (!baud_tick1 && c < 2 * TX_DIV) begin @(negedge clk); c++; end
        @(negedge clk);
        check("tick1_width", 32'(baud_tick1), 32'd0);
        c = 1;
        while (!baud_tick1 && c < 2 * TX_DIV) begin @(negedge clk); c++; end
        check("tick1_period", 32'(c), 32'(TX_DIV));
        c = 0;
        while (!baud_tick2 && c < 2 * RX_DIV) begin @(negedge clk); c++; end
        @(negedge clk);
        check("tick2_width", 32'(baud_tick2), 32'd0);
        c = 1;
        while (!baud_tick2 && c < 2 * RX_DIV) begin @(negedge clk); c++; end
        check("tick2_period", 32'(c), 32'(RX_DIV));

        // Loopback: directed bytes then random bytes
        for (int i = 0; i < 11; i++) begin
            b = (i < 5) ? fixed[i] : 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send(b);
            wait_idle();
            repeat (4) @(negedge clk);
        end
        check("loopback_drain", 32'(exp_q.size()), 32'd0);

        // Frame timing for 0xA5 with an ignored mid-frame write of 0x3C
        frame    = {1'b1, 8'hA5, 1'b0};
        busy_cnt = 0;
        @(negedge clk);
        wr_en   = 1'b1;
        data_in = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        check("busy_after_wr", 32'(busy), 32'd1);
        busy_cnt += int'(busy);
        c = 0;
        while (tx && c < 3 * TX_DIV) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            c++;
        end
        check("start_edge_seen", 32'(tx), 32'd0);
        tx_arr[0] = tx;
        for (int j = 1; j < 10 * TX_DIV; j++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            tx_arr[j] = tx;
            if (j == 4 * TX_DIV) begin
                wr_en   = 1'b1;
                data_in = 8'h3C;
            end else if (j == 4 * TX_DIV + 1) begin
                wr_en = 1'b0;
            end
        end
        for (int i = 0; i < 10; i++) begin
            ok = 1'b1;
            for (int j = i * TX_DIV + 1; j <= (i + 1) * TX_DIV - 2; j++) begin
                if (tx_arr[j] !== frame[i]) ok = 1'b0;
            end
            check($sformatf("tx_bit%0d_stable", i), 32'(ok), 32'd1);
        end
        c = 0;
        while (busy && c < 2 * TX_DIV) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            c++;
        end
        check("busy_len_in_range",
              32'((busy_cnt >= int'(10 * TX_DIV)) && (busy_cnt <= int'(11 * TX_DIV + 1))), 32'd1);
        zeros     = 0;
        busy_seen = 0;
        repeat (22 * TX_DIV) begin
            @(negedge clk);
            if (!tx) zeros++;
            if (busy) busy_seen++;
        end
        check("no_second_frame_tx", 32'(zeros), 32'd0);
        check("no_second_frame_busy", 32'(busy_seen), 32'd0);
        check("timing_drain", 32'(exp_q.size()), 32'd0);

        // Short low glitch on rx must not produce a byte
        @(negedge clk);
        loopback = 1'b0;
        rx_drv   = 1'b0;
        repeat (3 * RX_DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * TX_DIV) @(negedge clk);
        check("glitch_rdy", 32'(rdy), 32'd0);

        // Framing error drops the byte
        inject(8'h55, 1'b0);
        check("ferr_rdy", 32'(rdy), 32'd0);
        check("ferr_data_out", 32'(data_out), 32'(last_good));

        // Random injected frames, some with a bad stop bit
        for (int i = 0; i < 8; i++) begin
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 3) != 0);
            if (stop_ok) exp_q.push_back(b);
            inject(b, stop_ok);
            check("rand_rdy_cleared", 32'(rdy), 32'd0);
            if (!stop_ok) check("rand_ferr_keep", 32'(data_out), 32'(last_good));
        end
        check("rand_drain", 32'(exp_q.size()), 32'd0);

        // Sticky rdy, overwrite while rdy=1, explicit clear
        auto_clr = 1'b0;
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        inject(b, 1'b1);
        check("sticky_rdy", 32'(rdy), 32'd1);
        b2 = b ^ 8'hFF;
        inject(b2, 1'b1);
        check("overwrite_data", 32'(data_out), 32'(b2));
        check("overwrite_rdy", 32'(rdy), 32'd1);
        clr_req = 1'b1;
        repeat (3) @(negedge clk);
        clr_req = 1'b0;
        @(negedge clk);
        check("clear_rdy", 32'(rdy), 32'd0);
        check("clear_keeps_data", 32'(data_out), 32'(b2));
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        inject(b, 1'b1);
        check("rdy_set_again", 32'(rdy), 32'd1);

        // Reset in the middle of a tx frame and a looped-back rx frame
        loopback = 1'b1;
        send(8'h99);
        repeat (5 * TX_DIV) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_rdy", 32'(rdy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rdy", 32'(rdy), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        rst      = 1'b0;
        auto_clr = 1'b1;
        exp_q.push_back(8'hCB);
        send(8'hCB);
        wait_idle();
        repeat (8) @(negedge clk);
        check("post_rst_data", 32'(data_out), 32'hCB);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
